prio_intr_ctrl: RTL and testbench

- Parametrised, clocked successor to the team's 27-channel combinational priority/interrupt decoder benchmark.
- Latches per-channel requests (edge or level), masks them, and arbitrates by fixed priority (lowest index wins) with nesting.
- Offers the winning channel ID over a valid/ready handshake and tracks in-service channels until end-of-interrupt (EOI).
- Serves as a sequential target for the power side-channel analysis flow.

---
 rtl/intr_pkg.sv | 17 +
 rtl/prio_intr_ctrl_if.sv | 25 ++
 rtl/prio_find_first.sv | 24 ++
 rtl/prio_intr_ctrl.sv | 135 +++++++++++++
 tb/tb_prio_intr_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for the priority interrupt controller: offer FSM states,
// the default channel count and the channel-ID width helper.
package intr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam int DEFAULT_NUM_CH = 27;

  // Width of a channel ID; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_intr_ctrl_if.sv
// Offer/accept and end-of-interrupt handshake bundle of prio_intr_ctrl.
// master = controller side, slave = interrupt consumer side.
interface prio_intr_ctrl_if
  import intr_pkg::*;
#(
  parameter int ID_W = id_width(DEFAULT_NUM_CH)
);

  logic            irq_valid_o;
  logic [ID_W-1:0] irq_id_o;
  logic            irq_ready_i;
  logic            eoi_valid_i;
  logic [ID_W-1:0] eoi_id_i;

  modport master (
    output irq_valid_o, irq_id_o,
    input  irq_ready_i, eoi_valid_i, eoi_id_i
  );

  modport slave (
    input  irq_valid_o, irq_id_o,
    output irq_ready_i, eoi_valid_i, eoi_id_i
  );

endinterface

// File: rtl/prio_find_first.sv
// Lowest-set-bit encoder: reports whether any bit is set and the index of
// the lowest one (index is 0 when nothing is set).
module prio_find_first #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);

  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/prio_intr_ctrl.sv
// Clocked fixed-priority interrupt controller with nesting.
// Requests latch into pending (edge or level per channel), are masked and
// bounded by the highest-priority in-service channel, and the lowest eligible
// index is offered over a valid/ready handshake. Accepted channels stay in
// service until an end-of-interrupt strobe retires them.
// Optional build macro PRIO_INTR_KEY_LOCK_EN adds key_i/KEY_VAL, which XOR
// the reported (and recorded) channel ID with key_i ^ KEY_VAL.
module prio_intr_ctrl
  import intr_pkg::*;
#(
  parameter int                NUM_CH    = DEFAULT_NUM_CH,
  parameter int                ID_W      = id_width(NUM_CH),
  parameter logic [NUM_CH-1:0] EDGE_MODE = {NUM_CH{1'b1}}
`ifdef PRIO_INTR_KEY_LOCK_EN
  ,
  parameter logic [ID_W-1:0]   KEY_VAL   = '0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [NUM_CH-1:0] mask_i,
  prio_intr_ctrl_if.master  bus,
`ifdef PRIO_INTR_KEY_LOCK_EN
  input  logic [ID_W-1:0]   key_i,
`endif
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] in_service_o,
  output logic              err_o
);

  state_t            state_reg;
  logic              irq_valid_reg;
  logic [ID_W-1:0]   irq_id_reg;
  logic              err_reg;
  logic [NUM_CH-1:0] pending_reg, pending_next;
  logic [NUM_CH-1:0] in_service_reg, in_service_next;

  logic [NUM_CH-1:0] acc_sel, eoi_sel, below_bound, eligible;
  logic              accept, eoi_hit;
  logic              bound_found, win_found;
  logic [ID_W-1:0]   bound_idx, win_idx, offer_id;

  assign accept = irq_valid_reg & bus.irq_ready_i;

  // Nesting bound: only channels above the most urgent in-service one compete.
  prio_find_first #(.W(NUM_CH), .IW(ID_W)) u_bound (
    .vec   (in_service_reg),
    .found (bound_found),
    .idx   (bound_idx)
  );

  prio_find_first #(.W(NUM_CH), .IW(ID_W)) u_win (
    .vec   (eligible),
    .found (win_found),
    .idx   (win_idx)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign acc_sel[gi]     = accept & (irq_id_reg == ID_W'(gi));
    assign eoi_sel[gi]     = bus.eoi_valid_i & (bus.eoi_id_i == ID_W'(gi));
    assign below_bound[gi] = ~bound_found | (ID_W'(gi) < bound_idx);
    assign eligible[gi]    = pending_reg[gi] & ~mask_i[gi] & ~in_service_reg[gi] & below_bound[gi];

    if (EDGE_MODE[gi]) begin : g_edge
      logic req_prev_reg;
      // remember the previous request level so each rising edge latches once
      always_ff @(posedge clk) begin
        if (!rst_n) req_prev_reg <= 1'b0;
        else        req_prev_reg <= req_i[gi];
      end
      // a fresh edge in the acceptance cycle keeps the channel pending
      assign pending_next[gi] = (req_i[gi] & ~req_prev_reg) | (pending_reg[gi] & ~acc_sel[gi]);
    end else begin : g_level
      assign pending_next[gi] = req_i[gi];
    end
  end

  // Retire the EOI target (only if it is really in service), then record the
  // accepted ID; with a corrupted key both may hit one bit and acceptance wins.
  assign eoi_hit         = |(eoi_sel & in_service_reg);
  assign in_service_next = (in_service_reg & ~eoi_sel) | acc_sel;

`ifdef PRIO_INTR_KEY_LOCK_EN
  assign offer_id = win_idx ^ (key_i ^ KEY_VAL);
`else
  assign offer_id = win_idx;
`endif

  // pending / in-service / sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg    <= '0;
      in_service_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      pending_reg    <= pending_next;
      in_service_reg <= in_service_next;
      if (bus.eoi_valid_i && !eoi_hit) err_reg <= 1'b1;
    end
  end

  // offer FSM: capture the winner in IDLE, hold it stable until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      irq_valid_reg <= 1'b0;
      irq_id_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            irq_valid_reg <= 1'b1;
            irq_id_reg    <= offer_id;
            state_reg     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (accept) begin
            irq_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.irq_valid_o = irq_valid_reg;
  assign bus.irq_id_o    = irq_id_reg;
  assign pending_o       = pending_reg;
  assign in_service_o    = in_service_reg;
  assign err_o           = err_reg;

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Self-checking bench for prio_intr_ctrl: directed scenarios plus a random
// phase, every cycle compared against a behavioural reference model.
module tb_prio_intr_ctrl;
  import intr_pkg::*;

  localparam int N  = 27;
  localparam int IW = 5;
  // channels 24..26 are level-sensitive, the rest edge-latched
  localparam logic [N-1:0] EM = 27'h0FF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  mask = '0;
  logic          ready = 1'b0;
  logic          eoi_valid = 1'b0;
  logic [IW-1:0] eoi_id = '0;
`ifdef PRIO_INTR_KEY_LOCK_EN
  logic [IW-1:0] key = '0;
`endif
  logic [N-1:0]  pending, in_service;
  logic          err;

  int checks = 0;
  int failures = 0;

  prio_intr_ctrl_if #(.ID_W(IW)) bus();
  assign bus.irq_ready_i = ready;
  assign bus.eoi_valid_i = eoi_valid;
  assign bus.eoi_id_i    = eoi_id;

  prio_intr_ctrl #(.NUM_CH(N), .ID_W(IW), .EDGE_MODE(EM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .mask_i       (mask),
    .bus          (bus),
`ifdef PRIO_INTR_KEY_LOCK_EN
    .key_i        (key),
`endif
    .pending_o    (pending),
    .in_service_o (in_service),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [N-1:0] m_pend, m_isv, m_prev;
  logic         m_valid, m_err;
  int           m_id;

  // advance the model by one clock using the inputs currently applied
  function automatic void model_step();
    logic [N-1:0] np, ni;
    int bound, win;
    bit acc;
    if (!rst_n) begin
      m_pend = '0; m_isv = '0; m_prev = '0;
      m_valid = 1'b0; m_id = 0; m_err = 1'b0;
      return;
    end
    acc = m_valid && ready;
    for (int i = 0; i < N; i++) begin
      if (EM[i]) np[i] = (req[i] && !m_prev[i]) || (m_pend[i] && !(acc && m_id == i));
      else       np[i] = req[i];
    end
    ni = m_isv;
    if (eoi_valid) begin
      if (int'(eoi_id) < N && m_isv[eoi_id]) ni[eoi_id] = 1'b0;
      else m_err = 1'b1;
    end
    if (acc && m_id < N) ni[m_id] = 1'b1;
    if (!m_valid) begin
      bound = N;
      for (int i = N - 1; i >= 0; i--) if (m_isv[i]) bound = i;
      win = -1;
      for (int i = bound - 1; i >= 0; i--) if (m_pend[i] && !mask[i] && !m_isv[i]) win = i;
      if (win >= 0) begin
        m_valid = 1'b1;
`ifdef PRIO_INTR_KEY_LOCK_EN
        m_id = win ^ int'(key);
`else
        m_id = win;
`endif
      end
    end else if (acc) begin
      m_valid = 1'b0;
    end
    m_pend = np; m_isv = ni; m_prev = req;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: model, edge, then compare every output against the model
  task automatic cycle();
    bit acc;
    acc = rst_n && m_valid === 1'b1 && ready;
    if (acc) $display("txn accept id=%0d t=%0t", m_id, $time);
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 64'(bus.irq_valid_o), 64'(m_valid));
    if (m_valid) chk("id", 64'(bus.irq_id_o), 64'(m_id));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("in_service", 64'(in_service), 64'(m_isv));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic pulse(input int ch);
    req[ch] = 1'b1;
    cycle();
    req[ch] = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.irq_valid_o !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_wait"}, 64'(bus.irq_valid_o), 64'd1);
  endtask

  task automatic do_accept();
    ready = 1'b1;
    cycle();
    ready = 1'b0;
  endtask

  task automatic do_eoi(input int ch);
    eoi_valid = 1'b1;
    eoi_id = IW'(ch);
    cycle();
    eoi_valid = 1'b0;
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_valid", 64'(bus.irq_valid_o), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    cycle();

    // single edge request on channel 5
    pulse(5);
    chk("t1_pend5", 64'(pending[5]), 64'd1);
    chk("t1_novalid", 64'(bus.irq_valid_o), 64'd0);
    cycle();
    chk("t1_valid", 64'(bus.irq_valid_o), 64'd1);
    chk("t1_id5", 64'(bus.irq_id_o), 64'd5);
    do_accept();
    chk("t1_isv5", 64'(in_service[5]), 64'd1);
    chk("t1_pend5_clr", 64'(pending[5]), 64'd0);
    do_eoi(5);

    // simultaneous 3 and 9: 3 first, 9 after EOI 3
    req[3] = 1'b1; req[9] = 1'b1;
    cycle();
    req = '0;
    wait_valid("t2a");
    chk("t2_id3", 64'(bus.irq_id_o), 64'd3);
    do_accept();
    do_eoi(3);
    wait_valid("t2b");
    chk("t2_id9", 64'(bus.irq_id_o), 64'd9);
    do_accept();
    do_eoi(9);

    // nesting: 10 in service, 4 preempts, 12 waits for EOI 10
    pulse(10);
    wait_valid("t3a");
    do_accept();
    req[4] = 1'b1; req[12] = 1'b1;
    cycle();
    req = '0;
    wait_valid("t3b");
    chk("t3_id4", 64'(bus.irq_id_o), 64'd4);
    do_accept();
    do_eoi(4);
    cycle(); cycle(); cycle();
    chk("t3_12_blocked", 64'(bus.irq_valid_o), 64'd0);
    chk("t3_pend12", 64'(pending[12]), 64'd1);
    do_eoi(10);
    wait_valid("t3c");
    chk("t3_id12", 64'(bus.irq_id_o), 64'd12);
    do_accept();
    do_eoi(12);

    // mask holds off channel 2 but it still latches
    mask[2] = 1'b1;
    pulse(2);
    cycle(); cycle();
    chk("t4_masked", 64'(bus.irq_valid_o), 64'd0);
    chk("t4_pend2", 64'(pending[2]), 64'd1);
    mask[2] = 1'b0;
    cycle();
    chk("t4_valid", 64'(bus.irq_valid_o), 64'd1);
    chk("t4_id2", 64'(bus.irq_id_o), 64'd2);
    do_accept();
    do_eoi(2);

    // random phase with legal EOIs only
    for (int k = 0; k < 800; k++) begin
      req = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) mask = N'($urandom & $urandom);
      ready = 1'($urandom_range(0, 1));
      eoi_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        int c;
        c = $urandom_range(0, N - 1);
        if (m_isv[c]) begin
          eoi_valid = 1'b1;
          eoi_id = IW'(c);
        end
      end
      cycle();
    end
    req = '0; mask = '0; ready = 1'b0; eoi_valid = 1'b0;

    // reset during an offer drops it without recording acceptance
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    pulse(7);
    wait_valid("t5");
    chk("t5_id7", 64'(bus.irq_id_o), 64'd7);
    rst_n = 1'b0;
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    rst_n = 1'b1;
    chk("t5_valid_drop", 64'(bus.irq_valid_o), 64'd0);
    chk("t5_isv_empty", 64'(in_service), 64'd0);
    cycle();

    // EOI protocol errors are sticky and leave in_service alone
    pulse(11);
    wait_valid("t6");
    do_accept();
    do_eoi(8);
    chk("t6_err_notsvc", 64'(err), 64'd1);
    chk("t6_isv_keep", 64'(in_service), 64'(1 << 11));
    do_eoi(30);
    chk("t6_err_range", 64'(err), 64'd1);
    chk("t6_isv_keep2", 64'(in_service), 64'(1 << 11));
    cycle(); cycle();
    chk("t6_err_sticky", 64'(err), 64'd1);
    rst_n = 1'b0;
    cycle();
    chk("t6_err_clr", 64'(err), 64'd0);
    rst_n = 1'b1;
    cycle();

`ifdef PRIO_INTR_KEY_LOCK_EN
    // wrong key corrupts the ID, correct key is transparent
    key = 5'd1;
    pulse(6);
    wait_valid("t7a");
    chk("t7_id7", 64'(bus.irq_id_o), 64'd7);
    key = 5'd0;
    do_accept();
    wait_valid("t7b");
    chk("t7_id6", 64'(bus.irq_id_o), 64'd6);
    do_accept();
    do_eoi(6);
    do_eoi(7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
